fft_peak_finder: RTL and testbench
==================================

Name: fft_peak_finder

Overview:
- Sits directly downstream of the 1024-point FFT magnitude stage.
- Consumes the per-bin magnitude stream (valid, 16-bit magnitude, 16-bit bin address) and tracks the strongest bin inside a configurable bin window for each frame.
- At frame end it outputs the peak bin, its magnitude, the converted frequency in Hz (f = bin*FS_HZ/2^LOG2N) and a "signal present" flag.
- Feeds the UART report and demodulator frequency-tuning logic.

Parameters:
- LOG2N, 10, log2 of FFT length; last bin = 2^LOG2N-1.
- FS_HZ, 50_000_000, ADC sample rate in Hz (32-bit unsigned).
- MIN_BIN, 1, lowest bin eligible for the peak (excludes DC).
- MAX_BIN, 511, highest eligible bin (positive-frequency half only).
- MIN_MAG, 64, magnitude threshold for m_peak_found.

Ports:
- sys_clk  in  1  system clock, 50 MHz
- sys_rst  in  1  asynchronous reset, active-high
- s_magni_valid  in  1  magnitude sample valid; no ready, so input is never stalled
- s_magni_data  in  16  unsigned bin magnitude
- s_magni_addr  in  16  bin index 0..2^LOG2N-1
- m_peak_valid  out  1  one-cycle pulse; result outputs are valid this cycle and held until the next pulse
- m_peak_addr  out  16  winning bin index
- m_peak_magni  out  16  winning bin magnitude
- m_peak_freq  out  32  winning bin frequency in Hz, truncated
- m_peak_found  out  1  1 when m_peak_magni >= MIN_MAG
- m_frame_err  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: all outputs 0, scanner in IDLE, best registers cleared. Reset asserted mid-frame discards the partial frame; no m_peak_valid is issued for it.
- Only cycles with s_magni_valid=1 are processed. Gaps of any length are tolerated, with no timeout.
- Scanner FSM has two states, IDLE and SCAN, plus an expected-address counter exp_addr.
- IDLE:
  - Valid sample with addr==0 -> SCAN, exp_addr<=1, best cleared (best_mag=0, best_addr=MIN_BIN), and the sample is evaluated.
  - Any other valid addr is ignored and does not raise an error.
- SCAN, valid sample with addr==exp_addr:
  - Evaluate the sample, then exp_addr<=exp_addr+1.
  - Evaluate means: if MIN_BIN<=addr<=MAX_BIN and data>best_mag (strict), update best_mag/best_addr. Ties therefore keep the lowest bin.
- SCAN, valid sample with addr!=exp_addr:
  - Pulse m_frame_err on the next cycle; no result is produced for the frame.
  - If the offending addr==0, restart the scan with it (same as IDLE entry); otherwise go to IDLE.
- Last bin (addr==2^LOG2N-1, in sequence):
  - The final candidate, including this sample, is snapshotted into hold registers and a calc strobe is raised. FSM -> IDLE.
  - A sample with addr==0 on the very next cycle must start a new frame; the output pipeline is independent of the scanner.
- Output pipeline, 2 stages:
  - Stage 1: prod = hold_addr * FS_HZ (48-bit unsigned).
  - Stage 2: m_peak_freq <= prod[LOG2N+31:LOG2N]; m_peak_addr/m_peak_magni <= hold values; m_peak_found <= (hold_mag >= MIN_MAG); m_peak_valid pulses.
  - Latency: m_peak_valid is high exactly 2 cycles after the cycle carrying the last bin.
- If no bin in the window exceeds 0, the output is addr=MIN_BIN, magni=0, found=0, and m_peak_valid still pulses.
- Out-of-window bins still advance exp_addr and are checked for sequence.
- Result outputs change only on an m_peak_valid cycle.

Test Plan:
- Tone frame: all bins mag 10, bin 20 mag 1000, continuous valid -> m_peak_valid 2 cycles after addr 1023; addr=20, magni=1000, freq=976562, found=1.
- Tie and window:
  - Bin 0 = 60000 and bin 700 = 50000, both outside the window, must be excluded.
  - Bins 30 and 40 both 500 -> addr=30, magni=500.
- Below threshold: all bins mag 50 -> addr=1, magni=50, found=0, valid still pulses once.
- Sequence break: addrs 0..100 then 102 -> m_frame_err single pulse, no m_peak_valid. Next frame 0..1023 with peak at bin 5 mag 300 -> addr=5, freq=244140.
- Back-to-back frames with no gap and random 1-3 cycle valid gaps inside each frame: frame A peak bin 100, frame B peak bin 200 -> two valid pulses. Results are 100/4882812 and 200/9765625, and A's outputs are held until B's pulse.
- Reset asserted at bin 500 of a frame, released, then a full frame with peak bin 7 -> only one m_peak_valid, addr=7; all outputs 0 during reset.

Source files
------------

// File: rtl/fft_peak_finder_if.sv
// Magnitude-stream input and peak-report output of the FFT peak finder.
// The master side (upstream FFT / test harness) drives the magnitude stream
// and observes the report. The slave side is the peak finder itself.
interface fft_peak_finder_if;
   logic        s_magni_valid;
   logic [15:0] s_magni_data;
   logic [15:0] s_magni_addr;
   logic        m_peak_valid;
   logic [15:0] m_peak_addr;
   logic [15:0] m_peak_magni;
   logic [31:0] m_peak_freq;
   logic        m_peak_found;
   logic        m_frame_err;

   modport master (
      output s_magni_valid, s_magni_data, s_magni_addr,
      input  m_peak_valid, m_peak_addr, m_peak_magni, m_peak_freq,
             m_peak_found, m_frame_err
   );

   modport slave (
      input  s_magni_valid, s_magni_data, s_magni_addr,
      output m_peak_valid, m_peak_addr, m_peak_magni, m_peak_freq,
             m_peak_found, m_frame_err
   );
endinterface

// File: rtl/fft_peak_finder.sv
// Per-frame peak search over the FFT magnitude stream.
// A two-state scanner follows the bin sequence 0..2^LOG2N-1. It tracks the
// strongest bin inside [MIN_BIN, MAX_BIN] and hands the final candidate to an
// independent output stage. That stage converts the bin to Hz and reports the
// result two cycles after the last bin. A sequence break aborts the frame
// with a one-cycle error pulse.
module fft_peak_finder #(
   parameter int unsigned LOG2N   = 10,
   parameter logic [31:0] FS_HZ   = 32'd50_000_000,
   parameter logic [15:0] MIN_BIN = 16'd1,
   parameter logic [15:0] MAX_BIN = 16'd511,
   parameter logic [15:0] MIN_MAG = 16'd64
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   fft_peak_finder_if.slave   bus
);

   localparam logic [15:0] LAST_BIN = 16'((1 << LOG2N) - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t      state_q, state_d;
   logic [15:0] exp_addr_q, exp_addr_d;
   logic [15:0] best_mag_q, best_mag_d;
   logic [15:0] best_addr_q, best_addr_d;
   logic [15:0] hold_mag_q, hold_mag_d;
   logic [15:0] hold_addr_q, hold_addr_d;
   logic        calc_q, calc_d;
   logic        err_q, err_d;
   logic        peak_valid_q, peak_valid_d;
   logic [15:0] peak_addr_q, peak_addr_d;
   logic [15:0] peak_magni_q, peak_magni_d;
   logic [31:0] peak_freq_q, peak_freq_d;
   logic        peak_found_q, peak_found_d;

   logic        is_start;
   logic        in_seq;
   logic        in_win;
   logic [15:0] base_mag, base_addr;
   logic [15:0] cand_mag, cand_addr;
   logic [31:0] freq_calc;

   // Candidate evaluation: a frame start compares against a cleared best,
   // otherwise against the running best. The strict compare keeps the lowest bin on ties.
   always_comb begin
      is_start  = bus.s_magni_valid && (bus.s_magni_addr == 16'd0);
      in_seq    = bus.s_magni_valid && (state_q == SCAN) &&
                  (bus.s_magni_addr == exp_addr_q);
      base_mag  = is_start ? 16'd0 : best_mag_q;
      base_addr = is_start ? MIN_BIN : best_addr_q;
      in_win    = (bus.s_magni_addr >= MIN_BIN) && (bus.s_magni_addr <= MAX_BIN);
      cand_mag  = base_mag;
      cand_addr = base_addr;
      if (in_win && (bus.s_magni_data > base_mag)) begin
         cand_mag  = bus.s_magni_data;
         cand_addr = bus.s_magni_addr;
      end
   end

   // Scanner next state. In SCAN, exp_addr is never 0, so addr 0 can never
   // be in sequence. A fresh addr 0 therefore always means (re)start.
   always_comb begin
      state_d     = state_q;
      exp_addr_d  = exp_addr_q;
      best_mag_d  = best_mag_q;
      best_addr_d = best_addr_q;
      hold_mag_d  = hold_mag_q;
      hold_addr_d = hold_addr_q;
      calc_d      = 1'b0;
      err_d       = 1'b0;
      if (in_seq) begin
         if (bus.s_magni_addr == LAST_BIN) begin
            state_d     = IDLE;
            hold_mag_d  = cand_mag;
            hold_addr_d = cand_addr;
            calc_d      = 1'b1;
         end else begin
            exp_addr_d  = exp_addr_q + 16'd1;
            best_mag_d  = cand_mag;
            best_addr_d = cand_addr;
         end
      end else if (is_start) begin
         state_d     = SCAN;
         exp_addr_d  = 16'd1;
         best_mag_d  = cand_mag;
         best_addr_d = cand_addr;
         err_d       = (state_q == SCAN);
      end else if (bus.s_magni_valid && (state_q == SCAN)) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   // Bin-to-Hz conversion on the held bin: (bin * FS_HZ) >> LOG2N, truncated.
   assign freq_calc = 32'((48'(hold_addr_q) * 48'(FS_HZ)) >> LOG2N);

   // Output stage: result registers load only on the report cycle and hold otherwise.
   always_comb begin
      peak_valid_d = calc_q;
      peak_addr_d  = peak_addr_q;
      peak_magni_d = peak_magni_q;
      peak_freq_d  = peak_freq_q;
      peak_found_d = peak_found_q;
      if (calc_q) begin
         peak_addr_d  = hold_addr_q;
         peak_magni_d = hold_mag_q;
         peak_freq_d  = freq_calc;
         peak_found_d = (hold_mag_q >= MIN_MAG);
      end
   end

   // State registers; reset discards any partial frame and pending report.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         exp_addr_q   <= 16'd0;
         best_mag_q   <= 16'd0;
         best_addr_q  <= 16'd0;
         hold_mag_q   <= 16'd0;
         hold_addr_q  <= 16'd0;
         calc_q       <= 1'b0;
         err_q        <= 1'b0;
         peak_valid_q <= 1'b0;
         peak_addr_q  <= 16'd0;
         peak_magni_q <= 16'd0;
         peak_freq_q  <= 32'd0;
         peak_found_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_addr_q   <= exp_addr_d;
         best_mag_q   <= best_mag_d;
         best_addr_q  <= best_addr_d;
         hold_mag_q   <= hold_mag_d;
         hold_addr_q  <= hold_addr_d;
         calc_q       <= calc_d;
         err_q        <= err_d;
         peak_valid_q <= peak_valid_d;
         peak_addr_q  <= peak_addr_d;
         peak_magni_q <= peak_magni_d;
         peak_freq_q  <= peak_freq_d;
         peak_found_q <= peak_found_d;
      end
   end

   assign bus.m_peak_valid = peak_valid_q;
   assign bus.m_peak_addr  = peak_addr_q;
   assign bus.m_peak_magni = peak_magni_q;
   assign bus.m_peak_freq  = peak_freq_q;
   assign bus.m_peak_found = peak_found_q;
   assign bus.m_frame_err  = err_q;

endmodule

// File: tb/tb_fft_peak_finder.sv
// Bench for fft_peak_finder: table of whole frames plus hand-written
// sequence-break, restart and mid-frame reset cases. A queue-based
// scoreboard carries expected reports from the driver to the output monitor.
module tb_fft_peak_finder;

   typedef struct {
      int base;
      int a0; int m0;
      int a1; int m1;
      int a2; int m2;
      int a3; int m3;
      int gaps;
      int e_addr; int e_mag; int e_freq; int e_found;
   } frame_t;

   typedef struct {
      int addr; int mag; int freq; int found; int cyc;
   } exp_t;

   localparam int NT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   vcnt = 0;
   int   err_cnt = 0;
   exp_t sb[$];
   exp_t last_exp = '{0, 0, 0, 0, 0};
   frame_t tbl [NT];

   fft_peak_finder_if mag_bus ();

   fft_peak_finder dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (mag_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic drive(input logic v, input int a, input int m);
      @(posedge clk);
      #1;
      mag_bus.s_magni_valid = v;
      mag_bus.s_magni_addr  = 16'(a);
      mag_bus.s_magni_data  = 16'(m);
   endtask

   function automatic int mag_for(input frame_t f, input int a);
      int m;
      m = f.base;
      if (a == f.a0) m = f.m0;
      if (a == f.a1) m = f.m1;
      if (a == f.a2) m = f.m2;
      if (a == f.a3) m = f.m3;
      return m;
   endfunction

   // Drives one complete frame; the expected report is queued with the
   // cycle of the last bin so the monitor can check latency.
   task automatic send_frame(input frame_t f);
      exp_t e;
      for (int a = 0; a < 1024; a++) begin
         if (f.gaps != 0 && a != 0 && $urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 3)) drive(1'b0, 0, 0);
         drive(1'b1, a, mag_for(f, a));
      end
      e = '{f.e_addr, f.e_mag, f.e_freq, f.e_found, cyc};
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 0);
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [64:0] act_vec;
      logic [64:0] exp_vec;
      exp_t e;
      act_vec = {mag_bus.m_peak_addr, mag_bus.m_peak_magni, mag_bus.m_peak_freq,
                 mag_bus.m_peak_found};
      if (rst) begin
         chk("reset_outputs", 96'({act_vec, mag_bus.m_peak_valid, mag_bus.m_frame_err}), 96'd0);
         last_exp = '{0, 0, 0, 0, 0};
      end else begin
         if (mag_bus.m_frame_err) err_cnt++;
         if (mag_bus.m_peak_valid) begin
            vcnt++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: got pulse at cycle %0d, required none", cyc);
            end else begin
               e = sb.pop_front();
               chk("peak_addr", 96'(mag_bus.m_peak_addr), 96'(e.addr));
               chk("peak_magni", 96'(mag_bus.m_peak_magni), 96'(e.mag));
               chk("peak_freq", 96'(mag_bus.m_peak_freq), 96'(e.freq));
               chk("peak_found", 96'(mag_bus.m_peak_found), 96'(e.found));
               chk("latency", 96'(cyc - e.cyc), 96'd2);
               last_exp = e;
            end
         end else begin
            exp_vec = {16'(last_exp.addr), 16'(last_exp.mag), 32'(last_exp.freq),
                       1'(last_exp.found)};
            chk("held_outputs", 96'(act_vec), 96'(exp_vec));
         end
      end
   end

   initial begin
      int v0;
      int e0;
      frame_t f5;
      frame_t f7;

      tbl[0] = '{10, 20, 1000, -1, 0, -1, 0, -1, 0, 0, 20, 1000, 976562, 1};
      tbl[1] = '{10, 0, 60000, 700, 50000, 30, 500, 40, 500, 0, 30, 500, 1464843, 1};
      tbl[2] = '{50, -1, 0, -1, 0, -1, 0, -1, 0, 0, 1, 50, 48828, 0};
      tbl[3] = '{0, -1, 0, -1, 0, -1, 0, -1, 0, 0, 1, 0, 48828, 0};
      tbl[4] = '{63, 511, 64, -1, 0, -1, 0, -1, 0, 0, 511, 64, 24951171, 1};
      tbl[5] = '{5, 1, 100, 512, 9000, -1, 0, -1, 0, 0, 1, 100, 48828, 1};
      tbl[6] = '{10, 100, 2000, -1, 0, -1, 0, -1, 0, 1, 100, 2000, 4882812, 1};
      tbl[7] = '{10, 200, 3000, -1, 0, -1, 0, -1, 0, 1, 200, 3000, 9765625, 1};
      f5 = '{10, 5, 300, -1, 0, -1, 0, -1, 0, 0, 5, 300, 244140, 1};
      f7 = '{10, 7, 700, -1, 0, -1, 0, -1, 0, 0, 7, 700, 341796, 1};

      mag_bus.s_magni_valid = 1'b0;
      mag_bus.s_magni_addr  = 16'd0;
      mag_bus.s_magni_data  = 16'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // Stray addresses while idle are ignored silently.
      drive(1'b1, 300, 9999);
      drive(1'b1, 5, 9999);
      idle(3);

      // Table frames, back-to-back with no gap between frames.
      for (int i = 0; i < NT; i++) send_frame(tbl[i]);
      idle(6);
      chk("table_drained", 96'(sb.size()), 96'd0);
      chk("table_valid_count", 96'(vcnt), 96'(NT));
      chk("table_no_err", 96'(err_cnt), 96'd0);

      // Sequence break: 0..100 then 102 aborts with one error pulse.
      v0 = vcnt;
      for (int a = 0; a <= 100; a++) drive(1'b1, a, 10);
      drive(1'b1, 102, 10);
      idle(6);
      chk("break_err_pulses", 96'(err_cnt), 96'd1);
      chk("break_no_valid", 96'(vcnt), 96'(v0));
      send_frame(f5);
      idle(6);
      chk("after_break_valid", 96'(vcnt), 96'(v0 + 1));

      // Addr 0 mid-frame: error pulse, then the same sample restarts a frame.
      v0 = vcnt;
      for (int a = 0; a <= 50; a++) drive(1'b1, a, 4000);
      send_frame(f5);
      idle(6);
      chk("restart_err_pulses", 96'(err_cnt), 96'd2);
      chk("restart_valid", 96'(vcnt), 96'(v0 + 1));

      // Reset at bin 500 discards the partial frame.
      v0 = vcnt;
      e0 = err_cnt;
      for (int a = 0; a <= 500; a++) drive(1'b1, a, (a == 400) ? 5000 : 10);
      @(posedge clk);
      #1;
      rst = 1'b1;
      mag_bus.s_magni_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      idle(2);
      send_frame(f7);
      idle(6);
      chk("reset_frame_valid", 96'(vcnt), 96'(v0 + 1));
      chk("reset_frame_no_err", 96'(err_cnt), 96'(e0));
      chk("final_drained", 96'(sb.size()), 96'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
